// File: rtl/bram_pingpong.sv
// Ping-pong coefficient buffer: two simple-dual-port banks with swap handshake,
// a zero-fill clear engine and optional output register (read latency 1 or 2).
module bram_pingpong #(
    parameter int D_SIZE   = 52,
    parameter int Q_DEPTH  = 8,
    parameter int OUT_REG  = 0,
    parameter int AUTO_CLR = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [Q_DEPTH-1:0] wr_addr,
    input  logic [D_SIZE-1:0]  wr_din,
    input  logic               rd_en,
    input  logic [Q_DEPTH-1:0] rd_addr,
    output logic [D_SIZE-1:0]  rd_dout,
    output logic               rd_valid,
    input  logic               swap_req,
    output logic               swap_ack,
    input  logic               clr_req,
    output logic               busy,
    output logic               wr_bank
);
    localparam int Q_SIZE = 1 << Q_DEPTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state_reg, state_next;
    logic [Q_DEPTH-1:0] clr_cnt_reg, clr_cnt_next;
    logic               clr_both_reg, clr_both_next;
    logic               wr_bank_reg, wr_bank_next;
    logic               swap_ack_reg, swap_ack_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= CLEAR;
            clr_cnt_reg  <= '0;
            clr_both_reg <= 1'b1;
            wr_bank_reg  <= 1'b0;
            swap_ack_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= clr_cnt_next;
            clr_both_reg <= clr_both_next;
            wr_bank_reg  <= wr_bank_next;
            swap_ack_reg <= swap_ack_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_cnt_next  = clr_cnt_reg;
        clr_both_next = clr_both_reg;
        wr_bank_next  = wr_bank_reg;
        swap_ack_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // A swap takes priority; a simultaneous clr_req is dropped.
                if (swap_req) begin
                    wr_bank_next  = ~wr_bank_reg;
                    swap_ack_next = 1'b1;
                    if (AUTO_CLR != 0) begin
                        state_next    = CLEAR;
                        clr_cnt_next  = '0;
                        clr_both_next = 1'b0;
                    end
                end else if (clr_req) begin
                    state_next    = CLEAR;
                    clr_cnt_next  = '0;
                    clr_both_next = 1'b0;
                end
            end
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (&clr_cnt_reg) begin
                    state_next    = IDLE;
                    clr_both_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic               clearing;
    logic [Q_DEPTH-1:0] bank_waddr;
    logic [D_SIZE-1:0]  bank_wdata;
    logic [1:0]         bank_we;
    logic [D_SIZE-1:0]  bank_rdata [2];

    assign clearing   = (state_reg == CLEAR);
    assign bank_waddr = clearing ? clr_cnt_reg : wr_addr;
    assign bank_wdata = clearing ? '0 : wr_din;

    logic               rd_bank_reg;
    logic [Q_DEPTH-1:0] rd_addr_reg;
    logic               rd_valid_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [D_SIZE-1:0] mem [Q_SIZE];

            assign bank_we[gi] = clearing ? (clr_both_reg || (wr_bank_reg == 1'(gi)))
                                          : (wr_en && (wr_bank_reg == 1'(gi)));

            always_ff @(posedge clk) begin
                if (bank_we[gi])
                    mem[bank_waddr] <= bank_wdata;
            end

            // Registered address, array read from it: block-RAM read port.
            assign bank_rdata[gi] = mem[rd_addr_reg];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_reg  <= '0;
            rd_bank_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en && !clr_both_reg;
            if (rd_en) begin
                rd_addr_reg <= rd_addr;
                rd_bank_reg <= ~wr_bank_reg;
            end
        end
    end

    logic [D_SIZE-1:0] rd_raw;
    assign rd_raw = bank_rdata[rd_bank_reg];

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [D_SIZE-1:0] rd_dout_reg;
            logic              rd_valid_pipe_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_dout_reg       <= '0;
                    rd_valid_pipe_reg <= 1'b0;
                end else begin
                    rd_dout_reg       <= rd_raw;
                    rd_valid_pipe_reg <= rd_valid_reg;
                end
            end

            assign rd_dout  = rd_dout_reg;
            assign rd_valid = rd_valid_pipe_reg;
        end else begin : g_comb
            assign rd_dout  = rd_raw;
            assign rd_valid = rd_valid_reg;
        end
    endgenerate

    assign busy     = clearing;
    assign wr_bank  = wr_bank_reg;
    assign swap_ack = swap_ack_reg;

endmodule

// File: doc/bram_pingpong.md
# bram_pingpong

Parametrised ping-pong coefficient buffer for the polynomial multiplier datapath. It holds two identical simple-dual-port banks: the producer writes one bank while the consumer reads the other. A swap handshake exchanges the roles of the two banks. A built-in clear engine zero-fills banks after reset, on request, or automatically after each swap. Optional output pipelining gives read latency 1 or 2.

## Interface
- D_SIZE, 52, word width in bits
- Q_DEPTH, 8, address width; each bank holds Q_SIZE = 1 << Q_DEPTH words
- OUT_REG, 0, 0: read latency 1; 1: extra output register, latency 2
- AUTO_CLR, 1, 1: zero-fill the new write bank after every swap
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe to current write bank
- wr_addr  in  Q_DEPTH  write address
- wr_din  in  D_SIZE  write data
- rd_en  in  1  read strobe to current read bank
- rd_addr  in  Q_DEPTH  read address
- rd_dout  out  D_SIZE  read data
- rd_valid  out  1  rd_dout carries data for an accepted read
- swap_req  in  1  level request to exchange banks; hold until swap_ack
- swap_ack  out  1  one-cycle pulse, swap performed
- clr_req  in  1  one-cycle request to zero-fill the current write bank
- busy  out  1  clear engine active; external writes ignored
- wr_bank  out  1  index of the current write bank; read bank = ~wr_bank

## Operation
- The FSM has two states, IDLE and CLEAR. A clear counter clr_cnt is Q_DEPTH bits. A flag clr_both selects whether CLEAR zero-fills both banks.
- Reset: state=CLEAR, clr_both=1, clr_cnt=0, wr_bank=0, swap_ack=0, rd_valid=0. Address and output registers reset to 0.
- CLEAR: each edge writes 0 to address clr_cnt.
  - If clr_both=1, the write goes to both banks; otherwise it goes to the write bank only.
  - clr_cnt increments each edge.
  - At clr_cnt = Q_SIZE-1 the write completes, and the FSM returns to IDLE with clr_both=0.
- In CLEAR:
  - wr_en is ignored.
  - swap_req is not acknowledged; it stays pending.
  - clr_req is ignored.
- IDLE with swap_req=1: the FSM toggles wr_bank and pulses swap_ack next cycle. If AUTO_CLR=1, it enters CLEAR with clr_both=0 for the new write bank.
- IDLE with clr_req=1 and swap_req=0: the FSM enters CLEAR with clr_both=0.
- swap_req and clr_req asserted together in IDLE: the swap wins and clr_req is dropped. With AUTO_CLR=1 the new write bank is cleared anyway.
- Writes: on an edge with wr_en=1 in IDLE, wr_din is stored at wr_addr in the bank selected by wr_bank before that edge.
- Reads: on an edge with rd_en=1, rd_addr and the read bank (~wr_bank before that edge) are registered. The array output is taken from the registered address.
- Reads are allowed in CLEAR; the read bank is untouched unless clr_both=1.
- rd_valid is forced to 0 for reads accepted while clr_both=1.
- The two banks are physically separate, so read and write never collide.
- Addresses wrap naturally at Q_SIZE; there is no out-of-range state.

## Timing
- Write at edge t: the data is readable from that bank after it becomes the read bank, i.e. for reads accepted at or after the edge following the swap.
- Read accepted at edge t:
  - OUT_REG=0: rd_dout and rd_valid are valid during cycle t+1 (after edge t).
  - OUT_REG=1: they are valid during cycle t+2.
- With OUT_REG=0, rd_dout follows the registered address combinationally and holds its value while rd_en=0. rd_valid=0 in that case.
- Swap accepted at edge t:
  - wr_bank toggles at edge t and swap_ack=1 during cycle t+1.
  - Reads and writes at edge t use the old banks.
  - swap_req must be low, or a new request, by edge t+1. If it is still high at edge t+1 it is treated as a new request once the FSM is in IDLE.
- Clear (swap- or request-triggered) starting at edge t: busy=1 from cycle t+1 through cycle t+Q_SIZE. The zero writes occur at edges t+1..t+Q_SIZE, and busy=0 from cycle t+Q_SIZE+1.
- Reset clear: busy=1 while rst is high and for Q_SIZE cycles after rst falls.
- rst asserted mid-clear or mid-read: all state restarts as at reset. In-flight reads are dropped (rd_valid=0).

## Test plan
- Reset with Q_DEPTH=4: busy is high for 16 cycles after rst falls. Afterwards, reading every address of both banks (via a swap) returns 0 with rd_valid=1.
- Fill bank 0 with addr+5, swap, and read addr 3 with OUT_REG=0: rd_dout=8 one cycle later. Repeat with OUT_REG=1: rd_dout=8 two cycles later.
- Write 0x1234 at address Q_SIZE-1 and swap: the read returns 0x1234. Swap twice with AUTO_CLR=1: the read of the same address returns 0.
- Assert swap_req during CLEAR: swap_ack is held off until busy falls, then pulses once and wr_bank toggles once.
- Assert swap_req and clr_req in the same cycle with AUTO_CLR=0: exactly one swap occurs, no clear occurs (busy stays 0), and old write-bank data is preserved.
- Assert rst at clr_cnt=7 during a clear: busy restarts and a full Q_SIZE clear of both banks follows. wr_bank=0 and wr_en during busy is ignored (the target address still reads 0).
